// File: rtl/fwd_operand_unit.sv
// fwd_operand_unit: EX-stage operand forwarding with retired-write history,
// load-use interlock FSM and a saturating stall-cycle counter.
module fwd_operand_unit #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int NUM_RS     = 2,
  parameter int HIST_DEPTH = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RS*RA_W-1:0]   ex_rs_addr,
  input  logic [NUM_RS*XLEN-1:0]   ex_rs_data,
  input  logic                     mem_valid,
  input  logic                     mem_reg_write,
  input  logic                     mem_is_load,
  input  logic [RA_W-1:0]          mem_rd_addr,
  input  logic [XLEN-1:0]          mem_alu_result,
  input  logic                     wb_valid,
  input  logic                     wb_reg_write,
  input  logic [RA_W-1:0]          wb_rd_addr,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     id_valid,
  input  logic [NUM_RS*RA_W-1:0]   id_rs_addr,
  input  logic                     ex_valid,
  input  logic                     ex_reg_write,
  input  logic                     ex_is_load,
  input  logic [RA_W-1:0]          ex_rd_addr,
  output logic [NUM_RS*XLEN-1:0]   ex_operand,
  output logic [NUM_RS*2-1:0]      ex_fwd_sel,
  output logic                     stall,
  output logic                     hazard_err,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int REM_W = 2;

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_WB   = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [1:0] SEL_HIST = 2'b11;

  typedef enum logic {IDLE, HOLD} state_e;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] addr;
    logic [XLEN-1:0] data;
  } hist_t;

  hist_t            hist_q [HIST_DEPTH];
  hist_t            hist_d [HIST_DEPTH];
  state_e           state_q, state_d;
  logic [REM_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wb_push;
  logic             load_hit;
  logic             id_match;
  logic             detect;

  assign wb_push = wb_valid & wb_reg_write & (wb_rd_addr != '0);

  // History shift: a WB write enters at entry 0, older entries move down.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    hist_d = hist_q;
    if (wb_push) begin
      hist_d[0] = '{valid: 1'b1, addr: wb_rd_addr, data: wb_data};
      for (int h = 1; h < HIST_DEPTH; h++) hist_d[h] = hist_q[h-1];
    end
  end

  // History register; only the valid bits need a reset value.
  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so all flops sample the same pre-edge values.
    if (!rst_n) begin
      // NOTE: the addr/data payload is don't-care while valid is low, so it is left unreset.
      for (int h = 0; h < HIST_DEPTH; h++) hist_q[h].valid <= 1'b0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Per-operand resolution; later assignments override earlier ones, giving
  // priority x0 > MEM (non-load) > WB > history (newest) > regfile.
  always_comb begin
    logic [RA_W-1:0] rs_a;
    logic [XLEN-1:0] res;
    logic [1:0]      sel;
    logic            mem_hit;
    logic            wb_hit;
    ex_operand = '0;
    ex_fwd_sel = '0;
    load_hit   = 1'b0;
    rs_a       = '0;
    res        = '0;
    sel        = SEL_RF;
    mem_hit    = 1'b0;
    wb_hit     = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      rs_a    = ex_rs_addr[i*RA_W +: RA_W];
      mem_hit = mem_valid & mem_reg_write & (mem_rd_addr == rs_a) & (mem_rd_addr != '0);
      wb_hit  = wb_valid & wb_reg_write & (wb_rd_addr == rs_a) & (wb_rd_addr != '0);
      res     = ex_rs_data[i*XLEN +: XLEN];
      sel     = SEL_RF;
      // History is ignored while reset is held; oldest first so the newest wins.
      for (int h = HIST_DEPTH - 1; h >= 0; h--) begin
        if (rst_n && hist_q[h].valid && (hist_q[h].addr == rs_a)) begin
          res = hist_q[h].data;
          sel = SEL_HIST;
        end
      end
      if (wb_hit) begin
        res = wb_data;
        sel = SEL_WB;
      end
      if (mem_hit && !mem_is_load) begin
        res = mem_alu_result;
        sel = SEL_MEM;
      end
      if (rs_a == '0) begin
        res = '0;
        sel = SEL_RF;
      end
      load_hit = load_hit | (mem_hit & mem_is_load);
      ex_operand[i*XLEN +: XLEN] = res;
      ex_fwd_sel[i*2 +: 2]       = sel;
    end
  end

  assign hazard_err = rst_n & load_hit;

  // Load-use detect: the EX load's destination is read by the ID instruction.
  always_comb begin
    id_match = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (id_rs_addr[i*RA_W +: RA_W] == ex_rd_addr) id_match = 1'b1;
    end
  end

  assign detect = rst_n & id_valid & ex_valid & ex_reg_write & ex_is_load &
                  (ex_rd_addr != '0) & id_match;

  // Interlock FSM next state: IDLE stalls on detect, HOLD extends the stall.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        stall = detect;
        if (detect && (LOAD_LAT > 1)) begin
          state_d  = HOLD;
          remain_d = REM_W'(LOAD_LAT - 1);
        end
      end
      HOLD: begin
        stall = rst_n;
        if (remain_q <= REM_W'(1)) begin
          state_d  = IDLE;
          remain_d = '0;
        end else begin
          remain_d = remain_q - REM_W'(1);
        end
      end
    endcase
  end

  // Saturating stall counter next value.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_operand_unit.sv
// tb_fwd_operand_unit: two instances (LOAD_LAT 2 / HIST 2 / CNT 16 and
// LOAD_LAT 3 / HIST 3 / CNT 4) driven from shared inputs, checked every cycle
// against a behavioural model, plus directed literal scenarios.
module tb_fwd_operand_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  ex_rs_addr;
  logic [63:0] ex_rs_data;
  logic        mem_valid, mem_reg_write, mem_is_load;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_alu_result;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [9:0]  id_rs_addr;
  logic        ex_valid, ex_reg_write, ex_is_load;
  logic [4:0]  ex_rd_addr;

  logic [63:0] op_o  [2];
  logic [3:0]  sel_o [2];
  logic        stall_o [2];
  logic        haz_o [2];
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_operand_unit #(.XLEN(32), .RA_W(5), .NUM_RS(2), .HIST_DEPTH(2), .LOAD_LAT(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_rd_addr(mem_rd_addr), .mem_alu_result(mem_alu_result),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
    .ex_operand(op_o[0]), .ex_fwd_sel(sel_o[0]), .stall(stall_o[0]), .hazard_err(haz_o[0]),
    .stall_cnt(cnt_a)
  );

  fwd_operand_unit #(.XLEN(32), .RA_W(5), .NUM_RS(2), .HIST_DEPTH(3), .LOAD_LAT(3), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_rd_addr(mem_rd_addr), .mem_alu_result(mem_alu_result),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
    .ex_operand(op_o[1]), .ex_fwd_sel(sel_o[1]), .stall(stall_o[1]), .hazard_err(haz_o[1]),
    .stall_cnt(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          lat   [2] = '{2, 3};
  int          depth [2] = '{2, 3};
  int          cmax  [2] = '{65535, 15};
  logic [4:0]  h_addr [2][4];
  logic [31:0] h_data [2][4];
  int          h_n [2];
  int          stall_until [2];
  int          m_cnt [2];
  int          cyc = 0;
  bit          model_ok = 1'b0;
  bit          det_now;

  function automatic bit model_detect();
    bit m = 1'b0;
    for (int i = 0; i < 2; i++) if (id_rs_addr[i*5 +: 5] == ex_rd_addr) m = 1'b1;
    return rst_n && id_valid && ex_valid && ex_reg_write && ex_is_load && ex_rd_addr != 0 && m;
  endfunction

  function automatic bit mem_match(input logic [4:0] a);
    return mem_valid && mem_reg_write && mem_rd_addr == a && a != 0;
  endfunction

  function automatic void model_op(input int k, input int i, output logic [31:0] v, output logic [1:0] s);
    logic [4:0] a;
    a = ex_rs_addr[i*5 +: 5];
    v = ex_rs_data[i*32 +: 32];
    s = 2'b00;
    if (a == 0) begin v = 32'h0; s = 2'b00; return; end
    if (mem_match(a) && !mem_is_load) begin v = mem_alu_result; s = 2'b10; return; end
    if (wb_valid && wb_reg_write && wb_rd_addr == a) begin v = wb_data; s = 2'b01; return; end
    if (rst_n) begin
      for (int h = 0; h < h_n[k]; h++) begin
        if (h_addr[k][h] == a) begin v = h_data[k][h]; s = 2'b11; return; end
      end
    end
  endfunction

  // Compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      logic [31:0] v;
      logic [1:0]  s;
      bit          hz;
      bit          st;
      hz = 1'b0;
      for (int i = 0; i < 2; i++) if (mem_match(ex_rs_addr[i*5 +: 5]) && mem_is_load) hz = 1'b1;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 2; i++) begin
          model_op(k, i, v, s);
          check($sformatf("m_op%0d_%0d", k, i), op_o[k][i*32 +: 32], v);
          check($sformatf("m_sel%0d_%0d", k, i), 32'(sel_o[k][i*2 +: 2]), 32'(s));
        end
        st = rst_n && ((cyc < stall_until[k]) || model_detect());
        check($sformatf("m_stall%0d", k), 32'(stall_o[k]), 32'(st));
        check($sformatf("m_haz%0d", k), 32'(haz_o[k]), 32'(rst_n && hz));
      end
      check("m_cnt0", 32'(cnt_a), 32'(m_cnt[0]));
      check("m_cnt1", 32'(cnt_b), 32'(m_cnt[1]));
    end
  end

  // Model state update at the clock edge.
  always @(posedge clk) begin
    det_now = model_detect();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        h_n[k] = 0;
        stall_until[k] = 0;
        m_cnt[k] = 0;
      end else begin
        if (((cyc < stall_until[k]) || det_now) && m_cnt[k] < cmax[k]) m_cnt[k]++;
        if (!(cyc < stall_until[k]) && det_now) stall_until[k] = cyc + lat[k];
        if (wb_valid && wb_reg_write && wb_rd_addr != 0) begin
          for (int h = 3; h > 0; h--) begin
            h_addr[k][h] = h_addr[k][h-1];
            h_data[k][h] = h_data[k][h-1];
          end
          h_addr[k][0] = wb_rd_addr;
          h_data[k][0] = wb_data;
          if (h_n[k] < depth[k]) h_n[k]++;
        end
      end
    end
    cyc++;
    if (!rst_n) model_ok = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic set_idle();
    mem_valid = 0; mem_reg_write = 0; mem_is_load = 0; mem_rd_addr = 0; mem_alu_result = 0;
    wb_valid = 0; wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
    id_valid = 0; id_rs_addr = 0;
    ex_valid = 0; ex_reg_write = 0; ex_is_load = 0; ex_rd_addr = 0;
    ex_rs_addr = 0; ex_rs_data = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_stall", 32'(stall_o[0]), 32'h0);
    check("rst_cnt", 32'(cnt_a), 32'h0);
    check("rst_haz", 32'(haz_o[0]), 32'h0);

    // Back-to-back ALU dependence: MEM beats WB.
    next_cycle();
    mem_valid = 1; mem_reg_write = 1; mem_rd_addr = 5; mem_alu_result = 32'h0000_00AA;
    wb_valid = 1; wb_reg_write = 1; wb_rd_addr = 5; wb_data = 32'h11;
    ex_rs_addr = {5'd2, 5'd5}; ex_rs_data = {32'h2222_2222, 32'h5555_5555};
    @(negedge clk);
    check("b2b_op0", op_o[0][31:0], 32'h0000_00AA);
    check("b2b_sel0", 32'(sel_o[0][1:0]), 32'h2);

    // x0 guard.
    next_cycle();
    set_idle();
    mem_valid = 1; mem_reg_write = 1; mem_rd_addr = 0; mem_alu_result = 32'hFFFF_FFFF;
    wb_valid = 1; wb_reg_write = 1; wb_rd_addr = 0; wb_data = 32'hFFFF_FFFF;
    ex_rs_addr = {5'd2, 5'd0}; ex_rs_data = {32'h2222_2222, 32'h5555_5555};
    @(negedge clk);
    check("x0_op0", op_o[0][31:0], 32'h0);
    check("x0_sel0", 32'(sel_o[0][1:0]), 32'h0);

    // WB at cycle n, then read from history at n+1.
    next_cycle();
    set_idle();
    wb_valid = 1; wb_reg_write = 1; wb_rd_addr = 7; wb_data = 32'h1234;
    next_cycle();
    set_idle();
    ex_rs_addr = {5'd1, 5'd7}; ex_rs_data = {32'h1111_1111, 32'h0000_DEAD};
    @(negedge clk);
    check("hist_op0", op_o[0][31:0], 32'h1234);
    check("hist_sel0", 32'(sel_o[0][1:0]), 32'h3);
    next_cycle();
    wb_valid = 1; wb_reg_write = 1; wb_rd_addr = 10; wb_data = 32'hA0A0;
    next_cycle();
    wb_rd_addr = 11; wb_data = 32'hB0B0;
    next_cycle();
    wb_valid = 0; wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
    @(negedge clk);
    check("evict_op0", op_o[0][31:0], 32'h0000_DEAD);
    check("evict_sel0", 32'(sel_o[0][1:0]), 32'h0);
    check("deep_op0", op_o[1][31:0], 32'h1234);
    check("deep_sel0", 32'(sel_o[1][1:0]), 32'h3);

    // Hazard error: MEM load matches operand 1.
    next_cycle();
    set_idle();
    mem_valid = 1; mem_reg_write = 1; mem_is_load = 1; mem_rd_addr = 9; mem_alu_result = 32'h9999_9999;
    ex_rs_addr = {5'd9, 5'd1}; ex_rs_data = {32'hCAFE_0001, 32'h0101_0101};
    @(negedge clk);
    check("haz_err", 32'(haz_o[0]), 32'h1);
    check("haz_op1", op_o[0][63:32], 32'hCAFE_0001);
    check("haz_sel1", 32'(sel_o[0][3:2]), 32'h0);

    // Load-use: EX load x3, ID reads x3; bubble follows.
    next_cycle();
    set_idle();
    ex_valid = 1; ex_reg_write = 1; ex_is_load = 1; ex_rd_addr = 3;
    id_valid = 1; id_rs_addr = {5'd4, 5'd3};
    @(negedge clk);
    check("lu_stall_c0", 32'(stall_o[0]), 32'h1);
    next_cycle();
    ex_valid = 0; ex_reg_write = 0; ex_is_load = 0; ex_rd_addr = 0;
    @(negedge clk);
    check("lu_stall_c1", 32'(stall_o[0]), 32'h1);
    next_cycle();
    @(negedge clk);
    check("lu_stall_c2", 32'(stall_o[0]), 32'h0);
    check("lu_cnt", 32'(cnt_a), 32'h2);
    check("lu3_stall_c2", 32'(stall_o[1]), 32'h1);
    next_cycle();
    @(negedge clk);
    check("lu3_stall_c3", 32'(stall_o[1]), 32'h0);
    check("lu3_cnt", 32'(cnt_b), 32'h3);

    // Reset on the second stall cycle of the LOAD_LAT=3 instance.
    next_cycle();
    ex_valid = 1; ex_reg_write = 1; ex_is_load = 1; ex_rd_addr = 3;
    @(negedge clk);
    check("rs_stall_c0", 32'(stall_o[1]), 32'h1);
    next_cycle();
    ex_valid = 0; ex_reg_write = 0; ex_is_load = 0; ex_rd_addr = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rs_stall_c1", 32'(stall_o[1]), 32'h0);
    check("rs_stall_a", 32'(stall_o[0]), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    set_idle();
    ex_rs_addr = {5'd10, 5'd11}; ex_rs_data = {32'h0000_0A0A, 32'h0000_BEEF};
    @(negedge clk);
    check("rs_stall_c2", 32'(stall_o[1]), 32'h0);
    check("rs_cnt", 32'(cnt_b), 32'h0);
    check("rs_hist_op0", op_o[1][31:0], 32'h0000_BEEF);
    check("rs_hist_sel0", 32'(sel_o[1][1:0]), 32'h0);
    check("rs_hist_op1", op_o[1][63:32], 32'h0000_0A0A);

    // Randomised phase against the model.
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      rst_n          = ($urandom_range(0, 99) != 0);
      mem_valid      = ($urandom_range(0, 3) != 0);
      mem_reg_write  = ($urandom_range(0, 3) != 0);
      mem_is_load    = ($urandom_range(0, 2) == 0);
      mem_rd_addr    = 5'($urandom_range(0, 7));
      mem_alu_result = $urandom;
      wb_valid       = ($urandom_range(0, 3) != 0);
      wb_reg_write   = ($urandom_range(0, 3) != 0);
      wb_rd_addr     = 5'($urandom_range(0, 7));
      wb_data        = $urandom;
      id_valid       = ($urandom_range(0, 3) != 0);
      id_rs_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_valid       = ($urandom_range(0, 3) != 0);
      ex_reg_write   = ($urandom_range(0, 3) != 0);
      ex_is_load     = ($urandom_range(0, 2) == 0);
      ex_rd_addr     = 5'($urandom_range(0, 7));
      ex_rs_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_rs_data     = {$urandom, $urandom};
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
